// File: rtl/axi4_lite_arb_pkg.sv
// Shared types for the AXI4-Lite requester arbiter.
// FSM encoding, WAIT_HI timeout and index-width helper.
package axi4_lite_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_HI,
    WAIT_LO,
    DONE
  } arb_state_t;

  localparam int WAIT_HI_TIMEOUT = 2;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi4_lite_req_arbiter_if.sv
// Command side of the shared axi4_lite_master: start pulses out,
// busy flags and read result back.
interface axi4_lite_req_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  write_start;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;
  logic [STRB_WIDTH-1:0] write_strobe;
  logic                  write_busy;
  logic                  read_start;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_busy;

  modport master (
    output write_start, write_addr, write_data, write_strobe,
    output read_start, read_addr,
    input  write_busy, read_busy, read_data
  );

  modport slave (
    input  write_start, write_addr, write_data, write_strobe,
    input  read_start, read_addr,
    output write_busy, read_busy, read_data
  );

endinterface

// File: rtl/axi4_lite_arb_picker.sv
// One-hot winner select. ARB_ROUND_ROBIN_EN: search from ptr;
// otherwise fixed priority, lowest index wins.
module axi4_lite_arb_picker
  import axi4_lite_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic [IDX_W-1:0]   ptr,
`endif
  output logic               found,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index
);

`ifdef ARB_ROUND_ROBIN_EN
  int               j;
  logic [IDX_W-1:0] sel;

  always_comb begin
    found = 1'b0;
    index = '0;
    j     = 0;
    sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      sel = IDX_W'(j);
      if (!found && valid[sel]) begin
        found = 1'b1;
        index = sel;
      end
    end
  end
`else
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid[IDX_W'(i)]) begin
        found = 1'b1;
        index = IDX_W'(i);
      end
    end
  end
`endif

  assign grant = found ? (NUM_REQ'(1) << index) : '0;

endmodule

// File: rtl/axi4_lite_req_arbiter.sv
// Shares one axi4_lite_master between NUM_REQ requesters, one
// transaction at a time. ARB_ROUND_ROBIN_EN selects round-robin.
module axi4_lite_req_arbiter
  import axi4_lite_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]       req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_wdata,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]   req_wstrb,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [NUM_REQ-1:0]                  req_done,
  output logic [DATA_WIDTH-1:0]               req_rdata,
  axi4_lite_req_arbiter_if.master             m
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam int SW    = DATA_WIDTH / 8;
  localparam int CW    = $clog2(WAIT_HI_TIMEOUT + 1);

  arb_state_t state, state_nxt;

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_v;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_v;
  logic [NUM_REQ-1:0][SW-1:0]         wstrb_v;

  logic [IDX_W-1:0]      owner, pick_idx;
  logic [NUM_REQ-1:0]    pick_grant, ready_q;
  logic                  pick_found, we_q, busy;
  logic                  grab, last_wait, capture;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [SW-1:0]         wstrb_q;
  logic [CW-1:0]         cnt;
`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]      rr_ptr;
`endif

  assign addr_v  = req_addr;
  assign wdata_v = req_wdata;
  assign wstrb_v = req_wstrb;

  axi4_lite_arb_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .valid (req_valid),
`ifdef ARB_ROUND_ROBIN_EN
    .ptr   (rr_ptr),
`endif
    .found (pick_found),
    .grant (pick_grant),
    .index (pick_idx)
  );

  always_comb begin
    state_nxt = state;
    busy      = we_q ? m.write_busy : m.read_busy;
    last_wait = (cnt == CW'(WAIT_HI_TIMEOUT - 1));
    unique case (state)
      IDLE:
        if (pick_found && !m.write_busy && !m.read_busy)
          state_nxt = ISSUE;
      ISSUE:
        state_nxt = WAIT_HI;
      WAIT_HI:
        if (busy)           state_nxt = WAIT_LO;
        else if (last_wait) state_nxt = DONE;
      WAIT_LO:
        if (!busy) state_nxt = DONE;
      DONE:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
    grab    = (state == IDLE) && (state_nxt == ISSUE);
    // a timed-out WAIT_HI means the slave answered with zero latency
    capture = !we_q && (state_nxt == DONE) &&
              ((state == WAIT_LO) || (state == WAIT_HI));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      owner   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      ready_q <= '0;
      cnt     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr  <= '0;
`endif
    end else begin
      state   <= state_nxt;
      ready_q <= grab ? pick_grant : '0;
      cnt     <= (state == WAIT_HI) ? cnt + 1'b1 : '0;
      if (grab) begin
        owner   <= pick_idx;
        we_q    <= req_we[pick_idx];
        addr_q  <= addr_v[pick_idx];
        wdata_q <= wdata_v[pick_idx];
        wstrb_q <= wstrb_v[pick_idx];
      end
      if (capture) rdata_q <= m.read_data;
`ifdef ARB_ROUND_ROBIN_EN
      if (state == DONE)
        rr_ptr <= (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
`endif
    end
  end

  assign req_ready      = ready_q;
  assign req_done       = (state == DONE) ? (NUM_REQ'(1) << owner) : '0;
  assign req_rdata      = rdata_q;
  assign m.write_start  = (state == ISSUE) && we_q;
  assign m.read_start   = (state == ISSUE) && !we_q;
  assign m.write_addr   = addr_q;
  assign m.write_data   = wdata_q;
  assign m.write_strobe = wstrb_q;
  assign m.read_addr    = addr_q;

endmodule

// File: tb/tb_axi4_lite_req_arbiter.sv
// Bench for axi4_lite_req_arbiter: vector table plus corner
// sequences, checked against a queue of expected transactions.
module tb_axi4_lite_req_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NR-1:0]         req_valid = '0;
  logic [NR-1:0]         req_we    = '0;
  logic [NR-1:0][AW-1:0] req_addr  = '0;
  logic [NR-1:0][DW-1:0] req_wdata = '0;
  logic [NR-1:0][3:0]    req_wstrb = '0;
  logic [NR-1:0]         req_ready;
  logic [NR-1:0]         req_done;
  logic [DW-1:0]         req_rdata;

  axi4_lite_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi4_lite_req_arbiter #(
    .NUM_REQ    (NR),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .req_ready (req_ready),
    .req_done  (req_done),
    .req_rdata (req_rdata),
    .m         (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        idx;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lat;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        idx;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lat;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;
  int n_done = 0;
  int n_start = 0;
  int slv_lat = 2;
  int scnt = 0;
  bit outstanding = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] slv_mem(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], 16'hC0DE};
  endfunction

  // slave: busy for slv_lat cycles after a start; 0 = never busy
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.write_busy <= 1'b0;
      bus.read_busy  <= 1'b0;
      bus.read_data  <= '0;
      scnt           <= 0;
    end else if (bus.write_start || bus.read_start) begin
      if (bus.read_start) bus.read_data <= slv_mem(bus.read_addr);
      if (slv_lat > 0) begin
        bus.write_busy <= bus.write_start;
        bus.read_busy  <= bus.read_start;
        scnt           <= slv_lat;
      end
    end else if (scnt > 0) begin
      scnt <= scnt - 1;
      if (scnt == 1) begin
        bus.write_busy <= 1'b0;
        bus.read_busy  <= 1'b0;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      if (req_ready != '0) chk("ready_onehot", 64'($onehot(req_ready)), 1);
      if (bus.write_start || bus.read_start) begin
        n_start++;
        chk("start_excl", 64'(bus.write_start && bus.read_start), 0);
        chk("no_overlap", 64'(outstanding), 0);
        outstanding = 1'b1;
        start_cyc   = cyc;
        if (exp_q.size() == 0) begin
          chk("start_expected", 0, 1);
        end else begin
          mon_e = exp_q[0];
          chk("start_dir", 64'(bus.write_start), 64'(mon_e.we));
          if (mon_e.we) begin
            chk("write_addr", bus.write_addr, mon_e.addr);
            chk("write_data", bus.write_data, mon_e.data);
            chk("write_strobe", 64'(bus.write_strobe), 64'(mon_e.strb));
          end else begin
            chk("read_addr", bus.read_addr, mon_e.addr);
          end
        end
      end
      if (req_done != '0) begin
        n_done++;
        outstanding = 1'b0;
        if (exp_q.size() == 0) begin
          chk("done_expected", 0, 1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("done_owner", 64'(req_done), 64'(2'b01 << mon_e.idx));
          chk("latency", 64'(cyc - start_cyc),
              64'((mon_e.lat == 0) ? 3 : mon_e.lat + 2));
          if (!mon_e.we) chk("rdata", req_rdata, mon_e.rdata);
        end
      end
    end
  end

  task automatic push(input logic idx, input logic we,
                      input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input int lat);
    exp_t e;
    e.idx   = idx;
    e.we    = we;
    e.addr  = addr;
    e.data  = data;
    e.strb  = strb;
    e.lat   = lat;
    e.rdata = we ? 32'h0 : slv_mem(addr);
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic idx, input logic we,
                       input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
    logic got;
    got            = 1'b0;
    req_we[idx]    = we;
    req_addr[idx]  = addr;
    req_wdata[idx] = data;
    req_wstrb[idx] = strb;
    req_valid[idx] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready[idx]) begin
        got = 1'b1;
        break;
      end
    end
    chk("req_ready_seen", 64'(got), 1);
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int k = 0; k < 2000; k++) begin
      if (n_done >= target) break;
      @(negedge clk);
    end
    chk("done_count", n_done, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vt[6];
  int   base;
  int   s0;

  initial begin
    vt[0] = '{idx:1'b0, we:1'b0, addr:32'h100, data:32'h0,
              strb:4'h0, lat:3};
    vt[1] = '{idx:1'b1, we:1'b1, addr:32'h20, data:32'h12345678,
              strb:4'b0011, lat:2};
    vt[2] = '{idx:1'b0, we:1'b0, addr:32'h40, data:32'h0,
              strb:4'h0, lat:0};
    vt[3] = '{idx:1'b1, we:1'b1, addr:32'h44, data:32'hCAFEF00D,
              strb:4'b1100, lat:0};
    vt[4] = '{idx:1'b0, we:1'b1, addr:32'h80, data:32'hA5A55A5A,
              strb:4'b1111, lat:1};
    vt[5] = '{idx:1'b1, we:1'b0, addr:32'h1234, data:32'h0,
              strb:4'h0, lat:5};

    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_req_done", 64'(req_done), 0);
    chk("rst_req_rdata", req_rdata, 0);
    chk("rst_write_start", 64'(bus.write_start), 0);
    chk("rst_read_start", 64'(bus.read_start), 0);
    chk("rst_write_addr", bus.write_addr, 0);
    chk("rst_read_addr", bus.read_addr, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      slv_lat = vt[i].lat;
      base    = n_done;
      s0      = n_start;
      push(vt[i].idx, vt[i].we, vt[i].addr, vt[i].data, vt[i].strb,
           vt[i].lat);
      drive(vt[i].idx, vt[i].we, vt[i].addr, vt[i].data, vt[i].strb);
      wait_done(base + 1);
      chk("start_count", 64'(n_start - s0), 1);
      @(negedge clk);
    end

    // both requesters together: req 0 first, then req 1
    slv_lat = 2;
    for (int r = 0; r < 2; r++) begin
      base = n_done;
      push(1'b0, 1'b0, 32'h200, 32'h0, 4'h0, 2);
      push(1'b1, 1'b1, 32'h204, 32'h0BADF00D, 4'b0101, 2);
      fork
        drive(1'b0, 1'b0, 32'h200, 32'h0, 4'h0);
        drive(1'b1, 1'b1, 32'h204, 32'h0BADF00D, 4'b0101);
      join
      wait_done(base + 2);
      @(negedge clk);
    end

    // reset while the slave is busy (WAIT_LO)
    slv_lat = 6;
    base    = n_done;
    push(1'b0, 1'b0, 32'h300, 32'h0, 4'h0, 6);
    drive(1'b0, 1'b0, 32'h300, 32'h0, 4'h0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req_ready", 64'(req_ready), 0);
    chk("mid_rst_req_done", 64'(req_done), 0);
    chk("mid_rst_read_start", 64'(bus.read_start), 0);
    chk("mid_rst_read_addr", bus.read_addr, 0);
    chk("mid_rst_req_rdata", req_rdata, 0);
    exp_q.delete();
    outstanding = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_done_after_rst", n_done, base);

    slv_lat = 2;
    push(1'b1, 1'b1, 32'h400, 32'h55AA55AA, 4'b1001, 2);
    drive(1'b1, 1'b1, 32'h400, 32'h55AA55AA, 4'b1001);
    wait_done(base + 1);
    @(negedge clk);

    // req 0 back-to-back reads
    slv_lat = 1;
    base    = n_done;
    s0      = n_start;
    for (int k = 0; k < 3; k++)
      push(1'b0, 1'b0, 32'h500 + 32'(4 * k), 32'h0, 4'h0, 1);
    for (int k = 0; k < 3; k++)
      drive(1'b0, 1'b0, 32'h500 + 32'(4 * k), 32'h0, 4'h0);
    wait_done(base + 3);
    chk("b2b_starts", 64'(n_start - s0), 3);
    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
